// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the multi-cycle MIPS datapath.
// Optional bne support is enabled by defining MC_BNE_EN.
module multicycle_control #(
    parameter int CNT_W   = 32,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               memReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               IRWrite,
    output logic               memToReg,
    output logic               ALUSrcA,
    output logic               regWrite,
    output logic               regDst,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               branchNe,
    output logic               illegalOp,
    output logic [3:0]         state,
    output logic [CNT_W-1:0]   instrCount
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              retire_d;
`ifdef MC_BNE_EN
    logic              bne_q, bne_d;
`endif

    always_comb begin
        state_d  = S_FETCH;
        retire_d = 1'b0;
        case (state_q)
            S_FETCH:     state_d = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = memReady ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: begin
                state_d  = memReady ? S_FETCH : S_MEM_WRITE;
                retire_d = memReady;
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
                state_d  = S_FETCH;
                retire_d = 1'b1;
            end
            default:     state_d = S_FETCH;
        endcase
    end

    assign count_d = retire_d ? count_q + CNT_W'(1) : count_q;

`ifdef MC_BNE_EN
    // Latch the branch sense in DECODE so BRANCH does not depend on opcode.
    assign bne_d = (state_q == S_DECODE) ? (opcode == OP_BNE) : bne_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
`ifdef MC_BNE_EN
            bne_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
`ifdef MC_BNE_EN
            bne_q   <= bne_d;
`endif
        end
    end

    always_comb begin
        logic [1:0] alu_op;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        IRWrite     = 1'b0;
        memToReg    = 1'b0;
        ALUSrcA     = 1'b0;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        branchNe    = 1'b0;
        illegalOp   = 1'b0;
        alu_op      = 2'b00;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    memRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = memReady;
                    PCWrite = memReady;
                end
                S_DECODE:   ALUSrcB = 2'b11;
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEM_READ: begin
                    memRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    memToReg = 1'b1;
                    regWrite = 1'b1;
                end
                S_MEM_WRITE: begin
                    memWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_R_EXEC: begin
                    ALUSrcA = 1'b1;
                    alu_op  = 2'b10;
                end
                S_R_WB: begin
                    regDst   = 1'b1;
                    regWrite = 1'b1;
                end
                S_ADDI_WB:  regWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    alu_op      = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
`ifdef MC_BNE_EN
                    branchNe    = bne_q;
`endif
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_ILLEGAL:  illegalOp = 1'b1;
                default: ;
            endcase
        end
        ALUOp      = '0;
        ALUOp[1:0] = alu_op;
    end

    assign state      = state_q;
    assign instrCount = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       memReady = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, memRead, memWrite, IRWrite;
    logic       memToReg, ALUSrcA, regWrite, regDst, branchNe, illegalOp;
    logic [1:0] PCSource, ALUSrcB;
    logic [2:0] ALUOp;
    logic [3:0] state;
    logic [3:0] instrCount;

    multicycle_control #(.CNT_W(4), .ALUOP_W(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite),
        .memToReg(memToReg), .ALUSrcA(ALUSrcA), .regWrite(regWrite),
        .regDst(regDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .branchNe(branchNe), .illegalOp(illegalOp),
        .state(state), .instrCount(instrCount)
    );

    always #5 clk = ~clk;

    logic [18:0] ctrl_vec;
    assign ctrl_vec = {PCWrite, PCWriteCond, IorD, memRead, memWrite, IRWrite,
                       memToReg, ALUSrcA, regWrite, regDst, PCSource, ALUSrcB,
                       ALUOp, branchNe, illegalOp};

    int tests = 0;
    int fails = 0;
    int model_cnt = 0;
    int irw_n, pcw_n, ill_n;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Control word required in each state, taken from the state table.
    function automatic logic [18:0] exp_ctrl(input int st, input logic mr, input logic [5:0] op);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, bne, ill;
        logic [1:0] pcs, asb, aop;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, bne, ill} = '0;
        pcs = 2'b00; asb = 2'b00; aop = 2'b00;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  asb = 2'b11;
            2, 10: begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            11: rw = 1;
            8:  begin
                asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01;
`ifdef MC_BNE_EN
                bne = (op == 6'h05);
`endif
            end
            9:  begin pcw = 1; pcs = 2'b10; end
            12: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, pcs, asb, 1'b0, aop, bne, ill};
    endfunction

    // Builds the expected state path of one instruction and drives it cycle by cycle.
    task automatic run_instr(input logic [5:0] op, input int fst, input int mst,
                             input int max_cyc, output int ncyc);
        int   seq[$];
        logic mrq[$];
        bit   retires = 0;
        for (int i = 0; i < fst; i++) begin seq.push_back(0); mrq.push_back(1'b0); end
        seq.push_back(0); mrq.push_back(1'b1);
        seq.push_back(1); mrq.push_back(1'($urandom_range(0, 1)));
        case (op)
            6'h23: begin
                seq.push_back(2); mrq.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < mst; i++) begin seq.push_back(3); mrq.push_back(1'b0); end
                seq.push_back(3); mrq.push_back(1'b1);
                seq.push_back(4); mrq.push_back(1'($urandom_range(0, 1)));
                retires = 1;
            end
            6'h2B: begin
                seq.push_back(2); mrq.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < mst; i++) begin seq.push_back(5); mrq.push_back(1'b0); end
                seq.push_back(5); mrq.push_back(1'b1);
                retires = 1;
            end
            6'h00: begin seq.push_back(6); seq.push_back(7); retires = 1; end
            6'h08: begin seq.push_back(10); seq.push_back(11); retires = 1; end
            6'h04: begin seq.push_back(8); retires = 1; end
            6'h02: begin seq.push_back(9); retires = 1; end
`ifdef MC_BNE_EN
            6'h05: begin seq.push_back(8); retires = 1; end
`endif
            default: seq.push_back(12);
        endcase
        while (mrq.size() < seq.size()) mrq.push_back(1'($urandom_range(0, 1)));
        ncyc = 0;
        for (int k = 0; k < seq.size() && k < max_cyc; k++) begin
            @(negedge clk);
            opcode   = op;
            memReady = mrq[k];
            #1;
            ncyc++;
            check_eq("state", 32'(state), 32'(seq[k]));
            check_eq("ctrl", 32'(ctrl_vec), 32'(exp_ctrl(seq[k], mrq[k], op)));
            check_eq("count", 32'(instrCount), 32'(model_cnt));
            irw_n += int'(IRWrite);
            pcw_n += int'(PCWrite);
            ill_n += int'(illegalOp);
        end
        if (retires && ncyc == seq.size()) model_cnt = (model_cnt + 1) % 16;
    endtask

    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset    = 1'b1;
            memReady = 1'($urandom_range(0, 1));
            opcode   = 6'($urandom_range(0, 63));
            #1;
            check_eq("rst_ctrl", 32'(ctrl_vec), 32'h0);
        end
        @(negedge clk);
        reset    = 1'b0;
        memReady = 1'b0;
        #1;
        check_eq("rst_state", 32'(state), 32'h0);
        check_eq("rst_count", 32'(instrCount), 32'h0);
        check_eq("rst_memread", 32'(memRead), 32'h1);
        model_cnt = 0;
    endtask

    task automatic check_idle(input string tag, input int exp_cnt);
        @(negedge clk);
        memReady = 1'b0;
        #1;
        check_eq({tag, "_state"}, 32'(state), 32'h0);
        check_eq({tag, "_count"}, 32'(instrCount), 32'(exp_cnt));
    endtask

    initial begin
        int n, total;
        logic [5:0] ops[8];
        logic [5:0] prog[6];
        ops  = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02, 6'h05, 6'h3F};
        prog = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02};
        irw_n = 0; pcw_n = 0; ill_n = 0;

        apply_reset(2);

        total = 0;
        for (int i = 0; i < 6; i++) begin
            run_instr(prog[i], 0, 0, 99, n);
            total += n;
        end
        check_eq("mix_cycles", 32'(total), 32'd23);
        check_idle("mix", 6);

        irw_n = 0; pcw_n = 0;
        run_instr(6'h23, 3, 2, 99, n);
        check_eq("stall_cycles", 32'(n), 32'd10);
        check_eq("stall_irwrite", 32'(irw_n), 32'd1);
        check_eq("stall_pcwrite", 32'(pcw_n), 32'd1);

        ill_n = 0;
        run_instr(6'h3F, 0, 0, 99, n);
        check_eq("ill_pulse", 32'(ill_n), 32'd1);
        check_eq("ill_cycles", 32'(n), 32'd3);
        check_idle("ill", 7);

        ill_n = 0;
        run_instr(6'h05, 0, 0, 99, n);
`ifdef MC_BNE_EN
        check_eq("bne_illegal", 32'(ill_n), 32'd0);
`else
        check_eq("bne_illegal", 32'(ill_n), 32'd1);
`endif

        apply_reset(1);
        for (int i = 0; i < 17; i++) run_instr(6'h00, 0, 0, 99, n);
        check_idle("wrap", 1);

        for (int i = 0; i < 60; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)]
                                             : 6'($urandom_range(0, 63));
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 99, n);
        end
        check_idle("rand", model_cnt);

        // Abort a lw in the middle of its MEM_READ stall.
        run_instr(6'h23, 0, 6, 5, n);
        check_eq("midrd_state", 32'(state), 32'd3);
        apply_reset(2);
        run_instr(6'h00, 0, 0, 99, n);
        check_idle("post_rst", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control unit for the multi-cycle MIPS datapath, replacing the single-cycle opcode decoder. Sequences each instruction through fetch, decode, execute, memory and write-back states and drives every datapath enable and mux select. Stalls on a memory-ready handshake and keeps a retired-instruction counter. Sits between the instruction register's opcode field and the shared-memory multi-cycle datapath.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `ALUOP_W`, default 2: width of `ALUOp`. Must be at least 2; codes occupy the low two bits, upper bits are zero.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `opcode`  in  6  instruction bits [31:26], valid from DECODE onward.
- `memReady`  in  1  memory access completes this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `memRead`, `memWrite`, `IRWrite`, `memToReg`, `ALUSrcA`, `regWrite`, `regDst`  out  1 each  datapath controls.
- `PCSource`  out  2  PC mux select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `ALUSrcB`  out  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- `ALUOp`  out  `ALUOP_W`  00 = add, 01 = subtract, 10 = funct-decoded.
- `branchNe`  out  1  inverts the zero test for `PCWriteCond`. Tied to 0 when `MC_BNE_EN` is undefined.
- `illegalOp`  out  1  one-cycle pulse for an unsupported opcode.
- `state`  out  4  current state encoding, for debug.
- `instrCount`  out  `CNT_W`  number of retired instructions.

## Operation
- States and encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5.
  - R_EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9, ADDI_EXEC = 10, ADDI_WB = 11, ILLEGAL = 12.
  - Encodings 13–15 go to FETCH on the next edge, with all outputs 0.
- Outputs are a pure decode of `state`, gated by `memReady` where noted. Any control not listed for a state is 0.
  - FETCH: `memRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00. `IRWrite` and `PCWrite` equal `memReady`. Stays in FETCH while `memReady`=0.
  - DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00. Next state by opcode:
    - 0x23 or 0x2B → MEM_ADDR
    - 0x00 → R_EXEC
    - 0x04 → BRANCH
    - 0x02 → JUMP
    - 0x08 → ADDI_EXEC
    - anything else → ILLEGAL
  - MEM_ADDR and ADDI_EXEC: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. MEM_ADDR goes to MEM_READ for lw and to MEM_WRITE for sw.
  - MEM_READ: `memRead`=1, `IorD`=1. Holds while `memReady`=0, then goes to MEM_WB.
  - MEM_WB: `regDst`=0, `memToReg`=1, `regWrite`=1.
  - MEM_WRITE: `memWrite`=1, `IorD`=1. Holds while `memReady`=0.
  - R_EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10.
  - R_WB: `regDst`=1, `memToReg`=0, `regWrite`=1.
  - ADDI_WB: `regDst`=0, `memToReg`=0, `regWrite`=1.
  - BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01.
  - JUMP: `PCWrite`=1, `PCSource`=10.
  - ILLEGAL: `illegalOp`=1, then FETCH. The PC has already advanced by 4, so the instruction is skipped.
- Retirement, i.e. when `instrCount` increments by 1:
  - Counted on the edge leaving MEM_WB, R_WB, ADDI_WB, BRANCH or JUMP.
  - Counted on the edge leaving MEM_WRITE while `memReady`=1.
  - ILLEGAL is not counted.
  - The counter wraps modulo 2^`CNT_W`.

## Timing
- Reset:
  - While `reset`=1, every control output and `illegalOp` is forced to 0 combinationally.
  - At the reset edge, `state` becomes FETCH and `instrCount` becomes 0.
  - `reset` has priority over everything, including a stall or a retirement in the same cycle.
- Cycles per instruction with `memReady` held at 1:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, bne, j: 3
  - illegal: 3
- Each cycle with `memReady`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Outputs stay stable during the stall.
- `opcode` is sampled only in DECODE and MEM_ADDR. It must be held stable from the `IRWrite` edge until the instruction retires.

## Configuration
- `MC_BNE_EN` defined:
  - Opcode 0x05 (bne) goes from DECODE to BRANCH.
  - In BRANCH, `branchNe`=1 for 0x05 and 0 for 0x04.
  - bne retires like beq.
- `MC_BNE_EN` undefined: opcode 0x05 goes to ILLEGAL, and `branchNe` is tied to 0.

## Test plan
- Reset check: assert `reset` for 2 cycles in the middle of a MEM_READ stall.
  - Required: all controls 0 during reset, then `state`=0 and `instrCount`=0, and the next cycle is FETCH with `memRead`=1.
- Mixed program: with `memReady`=1, issue lw, sw, add, addi, beq, j.
  - Required: state sequences 0-1-2-3-4, 0-1-2-5, 0-1-6-7, 0-1-10-11, 0-1-8, 0-1-9.
  - Required: a total of 23 cycles and `instrCount`=6.
- Memory stalls: run lw with `memReady` low for 3 cycles in FETCH and 2 cycles in MEM_READ.
  - Required: 10 cycles total, and `IRWrite` and `PCWrite` pulse exactly once.
- Illegal opcode: issue opcode 0x3F.
  - Required: `illegalOp` high for exactly 1 cycle, `instrCount` unchanged, return to FETCH.
- Counter wrap: with `CNT_W`=4, retire 17 R-type instructions.
  - Required: `instrCount`=1.
- Branch-not-equal: issue opcode 0x05.
  - With `MC_BNE_EN` defined: BRANCH with `branchNe`=1 and `PCWriteCond`=1.
  - With `MC_BNE_EN` undefined: ILLEGAL with `illegalOp`=1.
